// File: rtl/pf_ram_arbiter.sv
// Playfield RAM arbiter: shares the single-port synchronous playfield RAM
// between the video tile fetcher (default winner) and the 6502 CPU.
// Pipeline: capture -> issue (RAM address regs) -> RAM access -> return.
// A starvation counter forces a CPU slot after STARVE_LIMIT lost arbitrations.
module pf_ram_arbiter #(
    parameter int unsigned AW           = 10,
    parameter int unsigned DW           = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          clk_12mhz,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    output logic          vid_overrun,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } tag_e;

    localparam logic [3:0] WAIT_LIM = 4'(STARVE_LIMIT);

    logic          vid_pend_q,    vid_pend_d;
    logic [AW-1:0] vid_addr_q,    vid_addr_d;
    logic          cpu_pend_q,    cpu_pend_d;
    logic          cpu_we_q,      cpu_we_d;
    logic [AW-1:0] cpu_addr_q,    cpu_addr_d;
    logic [DW-1:0] cpu_wdata_q,   cpu_wdata_d;
    logic [3:0]    cpu_wait_q,    cpu_wait_d;
    tag_e          tag1_q,        tag1_d;
    tag_e          tag2_q,        tag2_d;
    logic [DW-1:0] vid_data_q,    vid_data_d;
    logic          vid_valid_q,   vid_valid_d;
    logic          vid_overrun_q, vid_overrun_d;
    logic [DW-1:0] cpu_rdata_q,   cpu_rdata_d;
    logic          cpu_ack_q,     cpu_ack_d;
    logic [AW-1:0] ram_addr_q,    ram_addr_d;
    logic          ram_we_q,      ram_we_d;
    logic [DW-1:0] ram_wdata_q,   ram_wdata_d;

    logic starved;
    logic issue_cpu;
    logic issue_vid;
    logic cpu_busy;

    // Next-state: arbitration/issue, starvation count, capture, pipeline advance and return
    always_comb begin
        vid_pend_d    = vid_pend_q;
        vid_addr_d    = vid_addr_q;
        cpu_pend_d    = cpu_pend_q;
        cpu_we_d      = cpu_we_q;
        cpu_addr_d    = cpu_addr_q;
        cpu_wdata_d   = cpu_wdata_q;
        cpu_wait_d    = cpu_wait_q;
        tag1_d        = TAG_NONE;
        tag2_d        = tag1_q;
        vid_data_d    = vid_data_q;
        vid_valid_d   = 1'b0;
        vid_overrun_d = vid_overrun_q;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_ack_d     = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_we_d      = 1'b0;
        ram_wdata_d   = ram_wdata_q;

        // Issue decision uses only the registered pend flags
        starved   = cpu_pend_q && (cpu_wait_q >= WAIT_LIM);
        issue_cpu = cpu_pend_q && (starved || !vid_pend_q);
        issue_vid = vid_pend_q && !issue_cpu;

        if (issue_cpu) begin
            tag1_d      = TAG_CPU;
            cpu_pend_d  = 1'b0;
            ram_addr_d  = cpu_addr_q;
            ram_we_d    = cpu_we_q;
            ram_wdata_d = cpu_wdata_q;
        end else if (issue_vid) begin
            tag1_d     = TAG_VID;
            vid_pend_d = 1'b0;
            ram_addr_d = vid_addr_q;
        end

        if (!cpu_pend_q || issue_cpu) begin
            cpu_wait_d = '0;
        end else if (issue_vid && (cpu_wait_q != '1)) begin
            cpu_wait_d = cpu_wait_q + 4'd1;
        end

        // A slot freed by this edge's video issue can take the new request
        if (vid_req) begin
            if (vid_pend_q && !issue_vid) begin
                vid_overrun_d = 1'b1;
            end else begin
                vid_pend_d = 1'b1;
                vid_addr_d = vid_addr;
            end
        end

        // Only one CPU access exists from capture through its ack cycle
        cpu_busy = cpu_pend_q || (tag1_q == TAG_CPU) || (tag2_q == TAG_CPU) || cpu_ack_q;
        if (cpu_req && !cpu_busy) begin
            cpu_pend_d  = 1'b1;
            cpu_we_d    = cpu_we;
            cpu_addr_d  = cpu_addr;
            cpu_wdata_d = cpu_wdata;
        end

        // cpu_we_q is stable until the ack, so it still describes the returning op
        if (tag2_q == TAG_VID) begin
            vid_valid_d = 1'b1;
            vid_data_d  = ram_rdata;
        end else if (tag2_q == TAG_CPU) begin
            cpu_ack_d = 1'b1;
            if (!cpu_we_q) begin
                cpu_rdata_d = ram_rdata;
            end
        end
    end

    // State registers; asynchronous reset discards in-flight operations
    always_ff @(posedge clk_12mhz or posedge reset) begin
        if (reset) begin
            vid_pend_q    <= 1'b0;
            vid_addr_q    <= '0;
            cpu_pend_q    <= 1'b0;
            cpu_we_q      <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_wdata_q   <= '0;
            cpu_wait_q    <= '0;
            tag1_q        <= TAG_NONE;
            tag2_q        <= TAG_NONE;
            vid_data_q    <= '0;
            vid_valid_q   <= 1'b0;
            vid_overrun_q <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_ack_q     <= 1'b0;
            ram_addr_q    <= '0;
            ram_we_q      <= 1'b0;
            ram_wdata_q   <= '0;
        end else begin
            vid_pend_q    <= vid_pend_d;
            vid_addr_q    <= vid_addr_d;
            cpu_pend_q    <= cpu_pend_d;
            cpu_we_q      <= cpu_we_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_wdata_q   <= cpu_wdata_d;
            cpu_wait_q    <= cpu_wait_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            vid_data_q    <= vid_data_d;
            vid_valid_q   <= vid_valid_d;
            vid_overrun_q <= vid_overrun_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_ack_q     <= cpu_ack_d;
            ram_addr_q    <= ram_addr_d;
            ram_we_q      <= ram_we_d;
            ram_wdata_q   <= ram_wdata_d;
        end
    end

    assign vid_data    = vid_data_q;
    assign vid_valid   = vid_valid_q;
    assign vid_overrun = vid_overrun_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_ack     = cpu_ack_q;
    assign ram_addr    = ram_addr_q;
    assign ram_we      = ram_we_q;
    assign ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_pf_ram_arbiter.sv
// Bench for pf_ram_arbiter: directed vector table, hand-written corner
// sequences (starvation, reset mid-op) and a randomized run against a
// transaction-level reference model with a shadow memory.
module tb_pf_ram_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_overrun;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pf_ram_arbiter #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_12mhz(clk),
        .reset(reset),
        .vid_req(vid_req),
        .vid_addr(vid_addr),
        .vid_data(vid_data),
        .vid_valid(vid_valid),
        .vid_overrun(vid_overrun),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack),
        .ram_addr(ram_addr),
        .ram_we(ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Playfield RAM: synchronous single port, read-first, with a bench load port
    logic [DW-1:0] mem [0:1023];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          vr;
        logic [AW-1:0] va;
        logic          cr;
        logic          cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          e_vv;
        logic [DW-1:0] e_vd;
        logic          e_ack;
        logic [DW-1:0] e_cd;
        logic          e_we;
        logic [AW-1:0] e_ra;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t row(logic vr, logic [AW-1:0] va, logic cr, logic cw,
                                 logic [AW-1:0] ca, logic [DW-1:0] cd,
                                 logic evv, logic [DW-1:0] evd, logic eack,
                                 logic [DW-1:0] ecd, logic ewe, logic [AW-1:0] era);
        vec_t v;
        v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.e_vv = evv; v.e_vd = evd; v.e_ack = eack; v.e_cd = ecd; v.e_we = ewe; v.e_ra = era;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            is_vid;
        logic [DW-1:0] data;
        bit            we;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] shadow [0:1023];
    bit            m_vp, m_cp, m_cwe, m_ovr;
    logic [AW-1:0] m_va, m_ca;
    logic [DW-1:0] m_cwd;
    int unsigned   m_wait;
    int            m_e;
    int            m_cpu_last;
    bit            e_vv, e_ack, e_rwe;
    logic [DW-1:0] e_vd, e_cd, e_rwd;
    logic [AW-1:0] e_ra;

    task automatic model_reset();
        ret_q.delete();
        m_vp = 0; m_cp = 0; m_cwe = 0; m_ovr = 0;
        m_va = '0; m_ca = '0; m_cwd = '0;
        m_wait = 0; m_e = 0; m_cpu_last = -100;
        e_vv = 0; e_ack = 0; e_rwe = 0;
        e_vd = '0; e_cd = '0; e_rwd = '0; e_ra = '0;
    endtask

    // One clock edge: pick the winner, record its result from the shadow
    // memory, apply capture rules, and report results due this edge.
    task automatic model_step();
        int   kind;
        bit   cp_pre;
        ret_t r;
        kind = 0;
        if (m_cp && m_wait >= LIMIT) kind = 2;
        else if (m_vp)               kind = 1;
        else if (m_cp)               kind = 2;
        e_rwe = 0;
        if (kind == 1) begin
            r.due = m_e + 2; r.is_vid = 1; r.data = shadow[m_va]; r.we = 0;
            ret_q.push_back(r);
            e_ra = m_va;
        end else if (kind == 2) begin
            r.due = m_e + 2; r.is_vid = 0; r.data = shadow[m_ca]; r.we = m_cwe;
            ret_q.push_back(r);
            if (m_cwe) shadow[m_ca] = m_cwd;
            e_ra = m_ca; e_rwe = m_cwe; e_rwd = m_cwd;
            m_cpu_last = m_e;
        end
        if (m_cp && kind == 1) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
        else                   m_wait = 0;
        if (vid_req) begin
            if (m_vp && kind != 1) m_ovr = 1;
            else begin m_vp = 1; m_va = vid_addr; end
        end else if (kind == 1) begin
            m_vp = 0;
        end
        cp_pre = m_cp;
        if (kind == 2) m_cp = 0;
        if (cpu_req && !cp_pre && (m_e >= m_cpu_last + 4)) begin
            m_cp = 1; m_cwe = cpu_we; m_ca = cpu_addr; m_cwd = cpu_wdata;
        end
        e_vv = 0; e_ack = 0;
        while (ret_q.size() > 0 && ret_q[0].due == m_e) begin
            r = ret_q.pop_front();
            if (r.is_vid) begin
                e_vv = 1; e_vd = r.data;
            end else begin
                e_ack = 1;
                if (!r.we) e_cd = r.data;
            end
        end
        m_e++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  nv, na, n;
        bit  acked, c_active, c_cool;
        logic [AW-1:0] exp_ra;

        reset = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        #1;
        chk("rst_vid_data", vid_data, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_vid_overrun", vid_overrun, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);

        tick();
        load(10'h155, 8'hA5);
        load(10'h001, 8'h11);
        load(10'h002, 8'h22);

        // video read, CPU write/read-back, then simultaneous video+CPU
        tbl[0]  = row(1'b1, 10'h155, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10'h000);
        tbl[1]  = row(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10'h155);
        tbl[2]  = row(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 10'h155);
        tbl[3]  = row(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h155);
        tbl[4]  = row(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 8'h3C, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h155);
        tbl[5]  = row(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 8'h3C, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, 10'h020);
        tbl[6]  = row(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 8'h3C, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h020);
        tbl[7]  = row(1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 8'h3C, 1'b0, 8'hA5, 1'b1, 8'h00, 1'b0, 10'h020);
        tbl[8]  = row(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h020);
        tbl[9]  = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h020);
        tbl[10] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h020);
        tbl[11] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 10'h020);
        tbl[12] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 8'h00, 1'b0, 8'hA5, 1'b1, 8'h3C, 1'b0, 10'h020);
        tbl[13] = row(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0, 10'h020);
        tbl[14] = row(1'b1, 10'h001, 1'b1, 1'b0, 10'h002, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0, 10'h020);
        tbl[15] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0, 10'h001);
        tbl[16] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 8'h00, 1'b0, 8'hA5, 1'b0, 8'h3C, 1'b0, 10'h002);
        tbl[17] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 8'h00, 1'b1, 8'h11, 1'b0, 8'h3C, 1'b0, 10'h002);
        tbl[18] = row(1'b0, 10'h000, 1'b1, 1'b0, 10'h002, 8'h00, 1'b0, 8'h11, 1'b1, 8'h22, 1'b0, 10'h002);
        tbl[19] = row(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 1'b0, 8'h11, 1'b0, 8'h22, 1'b0, 10'h002);

        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            vid_req = tbl[i].vr; vid_addr = tbl[i].va;
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cd;
            tick();
            chk($sformatf("tbl%0d_vid_valid", i), vid_valid, tbl[i].e_vv);
            chk($sformatf("tbl%0d_vid_data", i), vid_data, tbl[i].e_vd);
            chk($sformatf("tbl%0d_cpu_ack", i), cpu_ack, tbl[i].e_ack);
            chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_cd);
            chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].e_ra);
            chk($sformatf("tbl%0d_overrun", i), vid_overrun, 0);
            if (ram_we) chk($sformatf("tbl%0d_ram_wdata", i), ram_wdata, 8'h3C);
        end
        tick(); tick();

        // Starvation: video every cycle while the CPU read is held
        nv = 0; na = 0; acked = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h0AA;
        for (int e = 0; e <= 18; e++) begin
            vid_req  = (e <= 9);
            vid_addr = 10'h100 + 10'(e);
            if (acked) cpu_req = 1'b0;
            tick();
            if (vid_valid) nv++;
            if (cpu_ack) begin na++; acked = 1; end
            if (e >= 1 && e <= 10) begin
                if (e == 5)      exp_ra = 10'h0AA;
                else if (e == 6) exp_ra = 10'h104;
                else             exp_ra = 10'h100 + 10'(e - 1);
                chk($sformatf("starve_ram_addr_e%0d", e), ram_addr, exp_ra);
            end
            if (e == 4) chk("starve_overrun_before", vid_overrun, 0);
            if (e == 5) chk("starve_overrun_set", vid_overrun, 1);
        end
        chk("starve_vid_valid_count", nv, 9);
        chk("starve_cpu_ack_count", na, 1);
        chk("starve_overrun_sticky", vid_overrun, 1);

        // Reset during an in-flight CPU write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h030; cpu_wdata = 8'h77;
        tick();
        tick();
        chk("midrst_we_before", ram_we, 1);
        reset = 1'b1;
        #1;
        cpu_req = 1'b0;
        chk("midrst_ram_we_async", ram_we, 0);
        chk("midrst_overrun", vid_overrun, 0);
        chk("midrst_ram_addr", ram_addr, 0);
        chk("midrst_ram_wdata", ram_wdata, 0);
        chk("midrst_cpu_ack", cpu_ack, 0);
        chk("midrst_vid_data", vid_data, 0);
        chk("midrst_cpu_rdata", cpu_rdata, 0);
        tick();
        chk("midrst_ram_we_held", ram_we, 0);
        #7;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("postrst_no_ack", cpu_ack, 0);
            chk("postrst_no_valid", vid_valid, 0);
            chk("postrst_ram_we", ram_we, 0);
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cpu_ack && n < 8);
        cpu_req = 1'b0;
        chk("postrst_read_latency", n, 4);
        chk("postrst_read_data", cpu_rdata, 8'hA5);
        tick(); tick();

        // Randomized run against the reference model
        reset = 1'b1;
        vid_req = 1'b0; cpu_req = 1'b0;
        for (int a = 0; a < 16; a++) begin
            load(10'(a), 8'((a * 37 + 5) & 8'hFF));
            shadow[a] = 8'((a * 37 + 5) & 8'hFF);
        end
        model_reset();
        reset = 1'b0;
        c_active = 0; c_cool = 0;
        for (int c = 0; c < 3000; c++) begin
            vid_req  = ($urandom_range(1) == 1);
            vid_addr = 10'($urandom_range(15));
            if (c_cool) begin
                cpu_req = 1'b0;
                c_cool  = 0;
            end else if (!c_active && $urandom_range(2) == 0) begin
                c_active  = 1;
                cpu_req   = 1'b1;
                cpu_we    = ($urandom_range(1) == 1);
                cpu_addr  = 10'($urandom_range(15));
                cpu_wdata = 8'($urandom);
            end
            model_step();
            tick();
            chk("rnd_vid_valid", vid_valid, e_vv);
            chk("rnd_vid_data", vid_data, e_vd);
            chk("rnd_cpu_ack", cpu_ack, e_ack);
            chk("rnd_cpu_rdata", cpu_rdata, e_cd);
            chk("rnd_ram_we", ram_we, e_rwe);
            chk("rnd_ram_addr", ram_addr, e_ra);
            chk("rnd_vid_overrun", vid_overrun, m_ovr);
            if (e_rwe) chk("rnd_ram_wdata", ram_wdata, e_rwd);
            if (e_ack) begin
                c_active = 0;
                c_cool   = 1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pf_ram_arbiter.md
# pf_ram_arbiter

Arbiter sharing the single-port synchronous playfield RAM between the video tile fetcher and the 6502 CPU in the centipede core. The video fetcher wins by default; a starvation counter guarantees the CPU a slot after a bounded wait. The block issues at most one RAM operation per cycle through a 3-stage registered pipeline. It sits between the CPU bus decode, the video timing/fetch logic and the playfield RAM macro.

## Interface
- AW, 10, RAM address width
- DW, 8, RAM data width
- STARVE_LIMIT, 4, lost arbitrations after which a pending CPU request beats video (1..15)

- clk_12mhz  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- vid_req  in  1  one-cycle pulse: video read request
- vid_addr  in  AW  video read address, sampled with vid_req
- vid_data  out  DW  video read data, valid while vid_valid=1
- vid_valid  out  1  one-cycle pulse: vid_data valid
- vid_overrun  out  1  sticky: a video request was dropped
- cpu_req  in  1  level request, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle pulse: CPU access complete
- ram_addr  out  AW  registered RAM address
- ram_we  out  1  registered RAM write enable
- ram_wdata  out  DW  registered RAM write data
- ram_rdata  in  DW  RAM read data, one cycle after address edge

## Operation
- Capture (edge E0): vid_req=1 loads vid_pend/vid_addr_q. If vid_pend already set (not yet issued), the new request is dropped, vid_overrun set; the pending request is kept. cpu_req=1 with cpu_pend=0, no CPU op in flight and cpu_ack=0 loads cpu_pend and we/addr/wdata.
- Issue (edge E1): from registered pend flags only. cpu_pend and cpu_wait>=STARVE_LIMIT -> CPU; else vid_pend -> video; else cpu_pend -> CPU; else idle (ram_we=0, ram_addr holds). Issue clears that pend flag and loads stage tag {none,vid,cpu}.
- cpu_wait: 4-bit saturating; +1 each cycle cpu_pend=1 and video issued; cleared when CPU issues or cpu_pend=0.
- RAM (edge E2): RAM performs read/write; tag advances.
- Return (edge E3): tag vid -> vid_data<=ram_rdata, vid_valid=1. Tag cpu -> cpu_ack=1; cpu_rdata<=ram_rdata on reads, holds on writes.
- CPU must drop cpu_req the cycle after sampling cpu_ack; cpu_req high in the ack cycle is ignored.
- Ordering: ops complete in issue order; a write issued at cycle N is seen by any read issued at N+1 or later.
- ram_we is 1 for exactly the one cycle following a CPU-write issue.

## Timing
- Uncontended latency: request edge E0 -> vid_valid/cpu_ack high after E3 (3 cycles), single-cycle pulse.
- Throughput: one op per cycle; back-to-back issue allowed.
- Worst CPU wait: STARVE_LIMIT lost arbitrations + 3 cycles.
- Reset values: vid_data=0, vid_valid=0, vid_overrun=0, cpu_rdata=0, cpu_ack=0, ram_addr=0, ram_we=0, ram_wdata=0; pend flags, tags, cpu_wait=0.
- Reset mid-operation: ram_we drops asynchronously; in-flight ops discarded, no vid_valid/cpu_ack for them after reset releases.
- Simultaneous vid_req and cpu_req, cpu_wait=0: video issues E1, CPU E2; cpu_ack one cycle after vid_valid.
- vid_overrun clears only on reset.

## Test plan
- Reset: pulse reset 20 ns mid-run -> all outputs 0 immediately, ram_we=0 while asserted.
- Video read: RAM[0x155]=0xA5, vid_req addr 0x155 -> vid_valid one cycle, vid_data=0xA5, 3 cycles after request edge.
- CPU write/read: write 0x3C to 0x020, ack, then read 0x020 -> two cpu_ack pulses, cpu_rdata=0x3C; ram_we high exactly one cycle.
- Contention: vid_req (0x001, data 0x11) and cpu_req read (0x002, data 0x22) same edge -> vid_valid/0x11 at E3, cpu_ack/0x22 at E4.
- Starvation: vid_req every cycle, cpu_req held -> CPU issued after exactly 4 video issues; that cycle's vid_req pending collision sets vid_overrun=1; no further ops lost.
- Reset mid-op: CPU write issued, reset asserted before E3 -> no cpu_ack, ram_we low, resumes cleanly on new request.
